// File: rtl/ifu_fetch.sv
// ifu_fetch -- instruction fetch front end.
//
// Holds the architectural PC and keeps at most one instruction-memory read
// outstanding. Each fetched word is presented to decode as {pc, instr} over a
// valid/ready handshake. A redirect from the next-PC unit replaces the PC.
// Any response that is still in flight for the old path is drained and
// discarded. Misaligned or out-of-window PCs never reach memory. They are
// presented as AdEL entries instead, with out_exc=1 and out_instr=0.
//
// Ports:
//   clk, reset_n                 clock (rising edge), synchronous active-low reset
//   redirect_valid, redirect_pc  non-sequential PC request from the next-PC unit
//   imem_req, imem_addr          read request / word address to instruction memory
//   imem_gnt                     memory accepts the request this cycle
//   imem_rvalid, imem_rdata      read response (exactly one per grant)
//   out_valid, out_ready         entry handshake with decode
//   out_pc, out_instr, out_exc   presented entry (out_exc = fetch address error)
module ifu_fetch #(
  parameter logic [31:0] PC_RESET = 32'h0000_3000,
  parameter logic [31:0] IM_BASE  = 32'h0000_3000,
  parameter logic [31:0] IM_BYTES = 32'h0000_4000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  output logic        out_exc
);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, DRAIN, HOLD} state_t;

  state_t      state_reg, state_next;
  logic [31:0] pc_reg, pc_next;
  logic [31:0] addr_reg;
  logic [31:0] out_pc_reg, out_instr_reg;
  logic        out_exc_reg;

  logic        go_req;        // the FSM wants to enter REQ with pc_next
  logic        pc_illegal;    // pc_next fails the fetch address check
  logic        capture_data;  // latch a memory response as the presented entry
  logic        capture_exc;   // latch an AdEL entry for pc_next

  // The window end is computed in 33 bits, so a window that reaches the top
  // of the address space does not wrap to zero.
  function automatic logic addr_illegal(input logic [31:0] a);
    logic [32:0] limit;
    limit = {1'b0, IM_BASE} + {1'b0, IM_BYTES};
    return (a[1:0] != 2'b00) || (a < IM_BASE) || ({1'b0, a} >= limit);
  endfunction

  always_comb begin
    state_next   = state_reg;
    pc_next      = pc_reg;
    go_req       = 1'b0;
    capture_data = 1'b0;
    capture_exc  = 1'b0;

    // A redirect has priority over every other transition. Only the
    // choice between REQ and DRAIN depends on whether a grant is still unanswered.
    case (state_reg)
      IDLE: begin
        if (redirect_valid) pc_next = redirect_pc;
        go_req = 1'b1;
      end
      REQ: begin
        if (redirect_valid) begin
          pc_next = redirect_pc;
          if (imem_gnt) state_next = DRAIN;
          else          go_req     = 1'b1;
        end else if (imem_gnt) begin
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (redirect_valid) begin
          pc_next = redirect_pc;
          if (imem_rvalid) go_req     = 1'b1;  // response dropped on the floor
          else             state_next = DRAIN;
        end else if (imem_rvalid) begin
          capture_data = 1'b1;
          state_next   = HOLD;
        end
      end
      DRAIN: begin
        if (redirect_valid) pc_next = redirect_pc;
        if (imem_rvalid) go_req = 1'b1;
      end
      HOLD: begin
        // A handshake in the same cycle as a redirect still counts as
        // delivered. Only the PC source differs.
        if (redirect_valid) begin
          pc_next = redirect_pc;
          go_req  = 1'b1;
        end else if (out_ready) begin
          pc_next = pc_reg + 32'd4;
          go_req  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase

    // Every entry into REQ is gated by the address check. A bad PC bypasses
    // memory and is presented directly as an exception entry.
    pc_illegal = addr_illegal(pc_next);
    if (go_req) begin
      if (pc_illegal) begin
        state_next  = HOLD;
        capture_exc = 1'b1;
      end else begin
        state_next = REQ;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg     <= IDLE;
      pc_reg        <= PC_RESET;
      addr_reg      <= 32'd0;
      out_pc_reg    <= 32'd0;
      out_instr_reg <= 32'd0;
      out_exc_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      // imem_addr only moves when a legal request is being set up. Otherwise
      // it keeps its last value.
      if (go_req && !pc_illegal) addr_reg <= pc_next;
      if (capture_data) begin
        out_pc_reg    <= pc_reg;
        out_instr_reg <= imem_rdata;
        out_exc_reg   <= 1'b0;
      end
      if (capture_exc) begin
        out_pc_reg    <= pc_next;
        out_instr_reg <= 32'd0;
        out_exc_reg   <= 1'b1;
      end
    end
  end

  assign imem_req  = (state_reg == REQ);
  assign imem_addr = addr_reg;
  assign out_valid = (state_reg == HOLD);
  assign out_pc    = out_pc_reg;
  assign out_instr = out_instr_reg;
  assign out_exc   = out_exc_reg;

endmodule
